ysyx_25040111_mem_arbiter_rr: RTL and testbench

//  N-master arbiter in front of the single LSU memory port (read + write channels).

---
 rtl/ysyx_25040111_mem_arbiter_rr_if.sv | 53 +++++
 rtl/ysyx_25040111_mem_arbiter_rr.sv | 196 +++++++++++++++++++
 tb/tb_ysyx_25040111_mem_arbiter_rr.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040111_mem_arbiter_rr_if.sv
// Bus bundle between the requesting masters, the arbiter and the single LSU port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface ysyx_25040111_mem_arbiter_rr_if #(
    parameter int NUM_MST = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LW      = 8
);
    logic [NUM_MST-1:0]    m_req_valid;
    logic [NUM_MST-1:0]    m_req_ready;
    logic [NUM_MST-1:0]    m_req_write;
    logic [NUM_MST*AW-1:0] m_req_addr;
    logic [NUM_MST*DW-1:0] m_req_wdata;
    logic [NUM_MST*2-1:0]  m_req_mask;
    logic [NUM_MST-1:0]    m_req_burst;
    logic [NUM_MST*LW-1:0] m_req_len;
    logic [NUM_MST-1:0]    m_req_sign;
    logic [NUM_MST-1:0]    m_rsp_valid;
    logic [DW-1:0]         m_rsp_data;
    logic                  m_rsp_last;

    logic                  lsu_rvalid;
    logic                  lsu_rready;
    logic [DW-1:0]         lsu_rdata;
    logic [AW-1:0]         lsu_raddr;
    logic [LW-1:0]         lsu_rlen;
    logic                  lsu_burst;
    logic [1:0]            lsu_rmask;
    logic                  lsu_rsign;
    logic                  lsu_wvalid;
    logic                  lsu_wready;
    logic [AW-1:0]         lsu_waddr;
    logic [DW-1:0]         lsu_wdata;
    logic [1:0]            lsu_wmask;

    modport slave (
        input  m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_mask,
               m_req_burst, m_req_len, m_req_sign,
               lsu_rready, lsu_rdata, lsu_wready,
        output m_req_ready, m_rsp_valid, m_rsp_data, m_rsp_last,
               lsu_rvalid, lsu_raddr, lsu_rlen, lsu_burst, lsu_rmask, lsu_rsign,
               lsu_wvalid, lsu_waddr, lsu_wdata, lsu_wmask
    );

    modport master (
        output m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_mask,
               m_req_burst, m_req_len, m_req_sign,
               lsu_rready, lsu_rdata, lsu_wready,
        input  m_req_ready, m_rsp_valid, m_rsp_data, m_rsp_last,
               lsu_rvalid, lsu_raddr, lsu_rlen, lsu_burst, lsu_rmask, lsu_rsign,
               lsu_wvalid, lsu_waddr, lsu_wdata, lsu_wmask
    );
endinterface

// File: rtl/ysyx_25040111_mem_arbiter_rr.sv
// N-master arbiter in front of the single LSU memory port: grants one request at a time
// (round-robin or fixed priority) and steers read beats / write acks back to the owner.
module ysyx_25040111_mem_arbiter_rr #(
    parameter int NUM_MST    = 2,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LW         = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    ysyx_25040111_mem_arbiter_rr_if.slave io_bus
);
    localparam int IW  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int IWP = IW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t         r_state;
    logic [IW-1:0]  r_ptr;
    logic [IW-1:0]  r_owner;
    logic [LW-1:0]  r_beat;
    logic [LW-1:0]  r_rlen;
    logic           r_rvalid;
    logic           r_burst;
    logic           r_rsign;
    logic [AW-1:0]  r_raddr;
    logic [1:0]     r_rmask;
    logic           r_wvalid;
    logic [AW-1:0]  r_waddr;
    logic [DW-1:0]  r_wdata;
    logic [1:0]     r_wmask;

    logic               w_any;
    logic               w_grant;
    logic               w_last;
    logic [IW-1:0]      w_win;
    logic [IW-1:0]      w_nxt;
    logic [IWP-1:0]     w_idx;
    logic [AW-1:0]      w_addr;
    logic [DW-1:0]      w_wdata;
    logic [1:0]         w_mask;
    logic [LW-1:0]      w_len;
    logic               w_write;
    logic               w_burst;
    logic               w_sign;
    logic [NUM_MST-1:0] w_rsp_valid;
    logic [DW-1:0]      w_rsp_data;
    logic               w_rsp_last;

    // Winner search: scan from the farthest candidate back to the nearest so the nearest set one sticks.
    always_comb begin
        w_win = '0;
        w_idx = '0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            if (FIXED_PRIO != 0) begin
                w_idx = IWP'(k);
            end else begin
                w_idx = IWP'(r_ptr) + IWP'(k);
                w_idx = (w_idx >= IWP'(NUM_MST)) ? (w_idx - IWP'(NUM_MST)) : w_idx;
            end
            w_win = io_bus.m_req_valid[w_idx[IW-1:0]] ? w_idx[IW-1:0] : w_win;
        end
    end

    assign w_any   = |io_bus.m_req_valid;
    assign w_grant = ~reset & (r_state == ST_IDLE) & w_any;
    assign w_nxt   = (w_win == IW'(NUM_MST - 1)) ? '0 : (w_win + IW'(1));
    assign w_addr  = io_bus.m_req_addr[int'(w_win)*AW +: AW];
    assign w_wdata = io_bus.m_req_wdata[int'(w_win)*DW +: DW];
    assign w_mask  = io_bus.m_req_mask[int'(w_win)*2 +: 2];
    assign w_len   = io_bus.m_req_len[int'(w_win)*LW +: LW];
    assign w_write = io_bus.m_req_write[w_win];
    assign w_burst = io_bus.m_req_burst[w_win];
    assign w_sign  = io_bus.m_req_sign[w_win];
    assign w_last  = (r_beat == r_rlen);

    // Response steering is combinational so a beat reaches its owner in the cycle the LSU completes it.
    always_comb begin
        w_rsp_valid = '0;
        w_rsp_data  = '0;
        w_rsp_last  = 1'b0;
        case (r_state)
            ST_RD: begin
                if (io_bus.lsu_rready && !reset) begin
                    w_rsp_valid = NUM_MST'(1) << r_owner;
                    w_rsp_data  = io_bus.lsu_rdata;
                    w_rsp_last  = w_last;
                end else begin
                    w_rsp_valid = '0;
                end
            end
            ST_WR: begin
                if (io_bus.lsu_wready && !reset) begin
                    w_rsp_valid = NUM_MST'(1) << r_owner;
                    w_rsp_last  = 1'b1;
                end else begin
                    w_rsp_valid = '0;
                end
            end
            default: begin
                w_rsp_valid = '0;
            end
        endcase
    end

    // Transaction FSM; LSU-facing fields are loaded on grant and cleared on completion so idle outputs read 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_beat   <= '0;
            r_rlen   <= '0;
            r_rvalid <= 1'b0;
            r_burst  <= 1'b0;
            r_rsign  <= 1'b0;
            r_raddr  <= '0;
            r_rmask  <= 2'b00;
            r_wvalid <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_wmask  <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_win;
                        r_ptr   <= w_nxt;
                        r_beat  <= '0;
                        if (w_write) begin
                            r_state  <= ST_WR;
                            r_wvalid <= 1'b1;
                            r_waddr  <= w_addr;
                            r_wdata  <= w_wdata;
                            r_wmask  <= w_mask;
                        end else begin
                            r_state  <= ST_RD;
                            r_rvalid <= 1'b1;
                            r_raddr  <= w_addr;
                            r_rmask  <= w_mask;
                            r_rsign  <= w_sign;
                            r_burst  <= w_burst;
                            r_rlen   <= w_burst ? w_len : '0;
                        end
                    end
                end
                ST_RD: begin
                    if (io_bus.lsu_rready) begin
                        r_beat <= r_beat + LW'(1);
                        if (w_last) begin
                            r_state  <= ST_IDLE;
                            r_rvalid <= 1'b0;
                            r_raddr  <= '0;
                            r_rmask  <= 2'b00;
                            r_rsign  <= 1'b0;
                            r_burst  <= 1'b0;
                            r_rlen   <= '0;
                        end
                    end
                end
                ST_WR: begin
                    if (io_bus.lsu_wready) begin
                        r_state  <= ST_IDLE;
                        r_wvalid <= 1'b0;
                        r_waddr  <= '0;
                        r_wdata  <= '0;
                        r_wmask  <= 2'b00;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.m_req_ready = w_grant ? (NUM_MST'(1) << w_win) : '0;
    assign io_bus.m_rsp_valid = w_rsp_valid;
    assign io_bus.m_rsp_data  = w_rsp_data;
    assign io_bus.m_rsp_last  = w_rsp_last;
    assign io_bus.lsu_rvalid  = r_rvalid;
    assign io_bus.lsu_raddr   = r_raddr;
    assign io_bus.lsu_rlen    = r_rlen;
    assign io_bus.lsu_burst   = r_burst;
    assign io_bus.lsu_rmask   = r_rmask;
    assign io_bus.lsu_rsign   = r_rsign;
    assign io_bus.lsu_wvalid  = r_wvalid;
    assign io_bus.lsu_waddr   = r_waddr;
    assign io_bus.lsu_wdata   = r_wdata;
    assign io_bus.lsu_wmask   = r_wmask;
endmodule

// File: tb/tb_ysyx_25040111_mem_arbiter_rr.sv
// Scoreboard bench: directed stimulus pushes expected grants/responses, a negedge monitor pops and compares.
// A second instance with fixed priority covers the priority-mode grant order.
module tb_ysyx_25040111_mem_arbiter_rr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [1:0]  gq [2][$];
    logic [34:0] rq [2][$];

    ysyx_25040111_mem_arbiter_rr_if #(.NUM_MST(2), .AW(32), .DW(32), .LW(8)) bus0 ();
    ysyx_25040111_mem_arbiter_rr_if #(.NUM_MST(2), .AW(32), .DW(32), .LW(8)) bus1 ();

    ysyx_25040111_mem_arbiter_rr #(.NUM_MST(2), .AW(32), .DW(32), .LW(8), .FIXED_PRIO(0)) dut0 (
        .clock (clk),
        .reset (rst),
        .io_bus(bus0)
    );
    ysyx_25040111_mem_arbiter_rr #(.NUM_MST(2), .AW(32), .DW(32), .LW(8), .FIXED_PRIO(1)) dut1 (
        .clock (clk),
        .reset (rst),
        .io_bus(bus1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [34:0] act, logic [34:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic req(int m, logic wr, logic [31:0] a, logic [31:0] wd, logic [1:0] mk,
                       logic bu, logic [7:0] ln, logic sg);
        bus0.m_req_valid[m]          = 1'b1;
        bus0.m_req_write[m]          = wr;
        bus0.m_req_addr[m*32 +: 32]  = a;
        bus0.m_req_wdata[m*32 +: 32] = wd;
        bus0.m_req_mask[m*2 +: 2]    = mk;
        bus0.m_req_burst[m]          = bu;
        bus0.m_req_len[m*8 +: 8]     = ln;
        bus0.m_req_sign[m]           = sg;
    endtask

    task automatic exp_rsp(int d, logic [1:0] v, logic [31:0] dt, logic l);
        rq[d].push_back({v, dt, l});
    endtask

    task automatic mon(int d, logic [1:0] rdy, logic [34:0] obs);
        logic [1:0]  eg;
        logic [34:0] er;
        if (rdy != 2'b00) begin
            if (gq[d].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL grant%0d: got %b, expected no grant", d, rdy);
            end else begin
                eg = gq[d].pop_front();
                chk($sformatf("grant%0d", d), 35'(rdy), 35'(eg));
            end
        end
        if (obs[34:33] != 2'b00) begin
            if (rq[d].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp%0d: got %h, expected no response", d, obs);
            end else begin
                er = rq[d].pop_front();
                chk($sformatf("rsp%0d", d), obs, er);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.m_req_ready, {bus0.m_rsp_valid, bus0.m_rsp_data, bus0.m_rsp_last});
        mon(1, bus1.m_req_ready, {bus1.m_rsp_valid, bus1.m_rsp_data, bus1.m_rsp_last});
    end

    initial begin
        bus0.m_req_valid = '0; bus0.m_req_write = '0; bus0.m_req_addr = '0; bus0.m_req_wdata = '0;
        bus0.m_req_mask = '0; bus0.m_req_burst = '0; bus0.m_req_len = '0; bus0.m_req_sign = '0;
        bus0.lsu_rready = 1'b0; bus0.lsu_rdata = '0; bus0.lsu_wready = 1'b0;
        bus1.m_req_valid = '0; bus1.m_req_write = '0; bus1.m_req_addr = '0; bus1.m_req_wdata = '0;
        bus1.m_req_mask = '0; bus1.m_req_burst = '0; bus1.m_req_len = '0; bus1.m_req_sign = '0;
        bus1.lsu_rready = 1'b0; bus1.lsu_rdata = '0; bus1.lsu_wready = 1'b0;

        // reset state: outputs idle even with a request pending
        tick();
        bus0.m_req_valid = 2'b01;
        #1;
        chk("rst_ready",  35'(bus0.m_req_ready), 35'd0);
        chk("rst_rvalid", 35'(bus0.lsu_rvalid),  35'd0);
        chk("rst_wvalid", 35'(bus0.lsu_wvalid),  35'd0);
        bus0.m_req_valid = 2'b00;
        tick();
        rst = 1'b0;
        tick();

        // 1: single read
        req(0, 1'b0, 32'h8000_0000, 32'h0, 2'b11, 1'b0, 8'd0, 1'b1);
        gq[0].push_back(2'b01);
        tick();
        bus0.m_req_valid[0] = 1'b0;
        chk("t1_rvalid", 35'(bus0.lsu_rvalid), 35'd1);
        chk("t1_raddr",  35'(bus0.lsu_raddr),  35'h8000_0000);
        chk("t1_rmask",  35'(bus0.lsu_rmask),  35'd3);
        chk("t1_rsign",  35'(bus0.lsu_rsign),  35'd1);
        chk("t1_rlen",   35'(bus0.lsu_rlen),   35'd0);
        chk("t1_wvalid", 35'(bus0.lsu_wvalid), 35'd0);
        tick();
        tick();
        bus0.lsu_rready = 1'b1;
        bus0.lsu_rdata  = 32'hDEAD_BEEF;
        exp_rsp(0, 2'b01, 32'hDEAD_BEEF, 1'b1);
        tick();
        bus0.lsu_rready = 1'b0;
        chk("t1_idle", 35'(bus0.lsu_rvalid), 35'd0);

        // 2: burst of 4
        req(0, 1'b0, 32'h8000_0100, 32'h0, 2'b11, 1'b1, 8'd3, 1'b0);
        gq[0].push_back(2'b01);
        tick();
        bus0.m_req_valid[0] = 1'b0;
        chk("t2_rlen",  35'(bus0.lsu_rlen),  35'd3);
        chk("t2_burst", 35'(bus0.lsu_burst), 35'd1);
        for (int i = 1; i <= 4; i++) begin
            bus0.lsu_rready = 1'b1;
            bus0.lsu_rdata  = 32'(i);
            exp_rsp(0, 2'b01, 32'(i), (i == 4));
            chk("t2_rvalid_hold", 35'(bus0.lsu_rvalid), 35'd1);
            tick();
        end
        bus0.lsu_rready = 1'b0;
        chk("t2_rvalid_drop", 35'(bus0.lsu_rvalid), 35'd0);

        // 3: both masters requesting continuously, LSU answers every cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        req(0, 1'b0, 32'h8000_0000, 32'h0, 2'b11, 1'b0, 8'd0, 1'b0);
        req(1, 1'b0, 32'h8000_0004, 32'h0, 2'b11, 1'b0, 8'd0, 1'b0);
        bus1.m_req_valid = 2'b11;
        bus0.lsu_rready = 1'b1; bus0.lsu_rdata = 32'h0000_1234;
        bus1.lsu_rready = 1'b1; bus1.lsu_rdata = 32'h0000_1234;
        for (int i = 0; i < 4; i++) begin
            gq[0].push_back((i % 2 == 0) ? 2'b01 : 2'b10);
            exp_rsp(0, (i % 2 == 0) ? 2'b01 : 2'b10, 32'h0000_1234, 1'b1);
            gq[1].push_back(2'b01);
            exp_rsp(1, 2'b01, 32'h0000_1234, 1'b1);
        end
        for (int i = 0; i < 8; i++) tick();
        bus0.m_req_valid = 2'b00; bus1.m_req_valid = 2'b00;
        bus0.lsu_rready = 1'b0; bus1.lsu_rready = 1'b0;

        // 4: write from master 1; a stray rready during WR must be ignored
        req(1, 1'b1, 32'h1000_0010, 32'h0000_55AA, 2'b01, 1'b0, 8'd0, 1'b0);
        gq[0].push_back(2'b10);
        tick();
        bus0.m_req_valid[1] = 1'b0;
        chk("t4_wvalid", 35'(bus0.lsu_wvalid), 35'd1);
        chk("t4_waddr",  35'(bus0.lsu_waddr),  35'h1000_0010);
        chk("t4_wdata",  35'(bus0.lsu_wdata),  35'h0000_55AA);
        chk("t4_wmask",  35'(bus0.lsu_wmask),  35'd1);
        chk("t4_rvalid", 35'(bus0.lsu_rvalid), 35'd0);
        tick();
        chk("t4_whold", 35'(bus0.lsu_wvalid), 35'd1);
        bus0.lsu_wready = 1'b1;
        bus0.lsu_rready = 1'b1;
        bus0.lsu_rdata  = 32'hFFFF_FFFF;
        exp_rsp(0, 2'b10, 32'h0, 1'b1);
        tick();
        bus0.lsu_wready = 1'b0;
        bus0.lsu_rready = 1'b0;
        chk("t4_wdrop", 35'(bus0.lsu_wvalid), 35'd0);

        // 5: reset after beat 2 of a 4-beat burst
        req(0, 1'b0, 32'h8000_0200, 32'h0, 2'b11, 1'b1, 8'd3, 1'b0);
        gq[0].push_back(2'b01);
        tick();
        bus0.m_req_valid[0] = 1'b0;
        bus0.lsu_rready = 1'b1;
        bus0.lsu_rdata  = 32'h11;
        exp_rsp(0, 2'b01, 32'h11, 1'b0);
        tick();
        bus0.lsu_rdata  = 32'h22;
        exp_rsp(0, 2'b01, 32'h22, 1'b0);
        tick();
        rst = 1'b1;
        bus0.lsu_rdata = 32'h33;
        req(1, 1'b0, 32'h8000_0400, 32'h0, 2'b11, 1'b1, 8'd1, 1'b0);
        #1;
        chk("t5_rvalid", 35'(bus0.lsu_rvalid),  35'd0);
        chk("t5_raddr",  35'(bus0.lsu_raddr),   35'd0);
        chk("t5_rlen",   35'(bus0.lsu_rlen),    35'd0);
        chk("t5_burst",  35'(bus0.lsu_burst),   35'd0);
        chk("t5_rspv",   35'(bus0.m_rsp_valid), 35'd0);
        chk("t5_ready",  35'(bus0.m_req_ready), 35'd0);
        tick();
        rst = 1'b0;
        bus0.lsu_rready = 1'b0;
        req(0, 1'b0, 32'h8000_0300, 32'h0, 2'b10, 1'b0, 8'd0, 1'b0);
        gq[0].push_back(2'b01);
        gq[0].push_back(2'b10);
        tick();
        bus0.m_req_valid[0] = 1'b0;
        bus0.lsu_rready = 1'b1;
        bus0.lsu_rdata  = 32'h44;
        exp_rsp(0, 2'b01, 32'h44, 1'b1);
        tick();
        bus0.lsu_rready = 1'b0;
        tick();
        bus0.m_req_valid[1] = 1'b0;
        chk("t5_m1_rlen",  35'(bus0.lsu_rlen),  35'd1);
        chk("t5_m1_raddr", 35'(bus0.lsu_raddr), 35'h8000_0400);
        bus0.lsu_rready = 1'b1;
        bus0.lsu_rdata  = 32'h55;
        exp_rsp(0, 2'b10, 32'h55, 1'b0);
        tick();
        bus0.lsu_rdata  = 32'h66;
        exp_rsp(0, 2'b10, 32'h66, 1'b1);
        tick();
        bus0.lsu_rready = 1'b0;
        chk("t5_idle", 35'(bus0.lsu_rvalid), 35'd0);
        tick();

        chk("gq0_empty", 35'(gq[0].size()), 35'd0);
        chk("rq0_empty", 35'(rq[0].size()), 35'd0);
        chk("gq1_empty", 35'(gq[1].size()), 35'd0);
        chk("rq1_empty", 35'(rq[1].size()), 35'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
